// File: rtl/aes_pkg.sv
// Shared AES constants and the request-arbiter state encoding.
package aes_pkg;

    localparam int unsigned AES_BLOCK_W      = 128;
    localparam int unsigned AES_KEY_W        = 128;
    localparam int unsigned AES_CORE_LATENCY = 41;

    localparam logic [1:0] ARB_IDLE  = 2'd0;
    localparam logic [1:0] ARB_ISSUE = 2'd1;
    localparam logic [1:0] ARB_WAIT  = 2'd2;
    localparam logic [1:0] ARB_RESP  = 2'd3;

    typedef enum logic [1:0] {
        StIdle  = ARB_IDLE,
        StIssue = ARB_ISSUE,
        StWait  = ARB_WAIT,
        StResp  = ARB_RESP
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping at NREQ-1.
module rr_arbiter #(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] gnt_idx
);

    localparam int unsigned IdxW  = $clog2(NREQ);
    localparam logic [IdxW:0] NreqW = (IdxW + 1)'(NREQ);

    // One extra bit so ptr + offset never overflows before the wrap.
    logic [IdxW:0] cand;
    logic          found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = {1'b0, ptr} + (IdxW + 1)'(i);
            if (cand >= NreqW) begin
                cand = cand - NreqW;
            end
            if (!found && req[cand[IdxW-1:0]]) begin
                found                  = 1'b1;
                gnt[cand[IdxW-1:0]]    = 1'b1;
                gnt_idx                = cand[IdxW-1:0];
            end
        end
    end

endmodule

// File: rtl/aes_req_arbiter.sv
// Shares one aes_core between NREQ requesters: round-robin accept, sequence the core,
// return the tagged ciphertext; a watchdog bounds each core transaction.
module aes_req_arbiter
    import aes_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NREQ-1:0]             req_valid,
    output logic [NREQ-1:0]             req_ready,
    input  logic [NREQ*AES_KEY_W-1:0]   req_key,
    input  logic [NREQ*AES_BLOCK_W-1:0] req_block,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic [$clog2(NREQ)-1:0]     resp_id,
    output logic [AES_BLOCK_W-1:0]      resp_data,
    output logic                        resp_err,
    output logic                        err_timeout,
    output logic                        core_start,
    output logic [AES_KEY_W-1:0]        core_key,
    output logic [AES_BLOCK_W-1:0]      core_block,
    input  logic                        core_busy,
    input  logic                        core_valid,
    input  logic [AES_BLOCK_W-1:0]      core_out
);

    localparam int unsigned IdxW = $clog2(NREQ);
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] TimeoutCnt = CntW'(TIMEOUT);
    localparam logic [IdxW-1:0] LastIdx    = IdxW'(NREQ - 1);

    arb_state_e state_q, state_d;
    logic [IdxW-1:0]        ptr_q, ptr_d;
    logic [IdxW-1:0]        id_q, id_d;
    logic [AES_KEY_W-1:0]   key_q, key_d;
    logic [AES_BLOCK_W-1:0] blk_q, blk_d;
    logic [AES_BLOCK_W-1:0] data_q, data_d;
    logic                   err_q, err_d;
    logic                   sticky_q, sticky_d;
    logic [CntW-1:0]        cnt_q, cnt_d;

    logic [AES_KEY_W-1:0]   key_arr [NREQ];
    logic [AES_BLOCK_W-1:0] blk_arr [NREQ];
    logic [NREQ-1:0]        gnt;
    logic [IdxW-1:0]        gnt_idx;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign key_arr[g] = req_key[g*AES_KEY_W +: AES_KEY_W];
        assign blk_arr[g] = req_block[g*AES_BLOCK_W +: AES_BLOCK_W];
    end

    rr_arbiter #(
        .NREQ(NREQ)
    ) u_rr (
        .req    (req_valid),
        .ptr    (ptr_q),
        .gnt    (gnt),
        .gnt_idx(gnt_idx)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        id_d       = id_q;
        key_d      = key_q;
        blk_d      = blk_q;
        data_d     = data_q;
        err_d      = err_q;
        sticky_d   = sticky_q;
        cnt_d      = cnt_q;
        req_ready  = '0;
        core_start = 1'b0;
        resp_valid = 1'b0;

        case (state_q)
            StIdle: begin
                // Busy gating covers the core's DONE cycle, which would drop a new start.
                if (!rst && !core_busy && (|req_valid)) begin
                    req_ready = gnt;
                    id_d      = gnt_idx;
                    key_d     = key_arr[gnt_idx];
                    blk_d     = blk_arr[gnt_idx];
                    ptr_d     = (gnt_idx == LastIdx) ? '0 : gnt_idx + 1'b1;
                    state_d   = StIssue;
                end
            end
            StIssue: begin
                core_start = 1'b1;
                cnt_d      = '0;
                state_d    = StWait;
            end
            StWait: begin
                cnt_d = cnt_q + 1'b1;
                if (core_valid) begin
                    data_d  = core_out;
                    err_d   = 1'b0;
                    state_d = StResp;
                end else if (cnt_d == TimeoutCnt) begin
                    data_d   = '0;
                    err_d    = 1'b1;
                    sticky_d = 1'b1;
                    state_d  = StResp;
                end
            end
            StResp: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            ptr_q    <= '0;
            id_q     <= '0;
            key_q    <= '0;
            blk_q    <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            id_q     <= id_d;
            key_q    <= key_d;
            blk_q    <= blk_d;
            data_q   <= data_d;
            err_q    <= err_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    assign resp_id     = id_q;
    assign resp_data   = data_q;
    assign resp_err    = err_q;
    assign err_timeout = sticky_q;
    assign core_key    = key_q;
    assign core_block  = blk_q;

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Directed bench for aes_req_arbiter with a behavioural aes_core stub.
module tb_aes_req_arbiter;
    import aes_pkg::*;

    localparam int unsigned NREQ    = 4;
    localparam int unsigned TIMEOUT = 64;

    localparam logic [127:0] FipsKey = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FipsPt  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FipsCt  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*128-1:0]   req_key;
    logic [NREQ*128-1:0]   req_block;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [1:0]            resp_id;
    logic [127:0]          resp_data;
    logic                  resp_err;
    logic                  err_timeout;
    logic                  core_start;
    logic [127:0]          core_key;
    logic [127:0]          core_block;
    logic                  core_busy;
    logic                  core_valid;
    logic [127:0]          core_out;

    logic [127:0] tb_key [NREQ];
    logic [127:0] tb_blk [NREQ];

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int gap_bad = 0;
    int stub_delay = 42;
    int stub_tail = 1;

    aes_req_arbiter #(
        .NREQ   (NREQ),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_key    (req_key),
        .req_block  (req_block),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .err_timeout(err_timeout),
        .core_start (core_start),
        .core_key   (core_key),
        .core_block (core_block),
        .core_busy  (core_busy),
        .core_valid (core_valid),
        .core_out   (core_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [127:0] core_model(input logic [127:0] k, input logic [127:0] b);
        return (k == FipsKey && b == FipsPt) ? FipsCt : (k ^ b);
    endfunction

    // Core stub: start sampled one edge after ISSUE; busy stays up stub_tail cycles past valid.
    initial begin : core_stub
        logic [127:0] ck;
        logic [127:0] cb;
        core_busy  = 1'b0;
        core_valid = 1'b0;
        core_out   = '0;
        forever begin
            @(negedge clk);
            if (core_start) begin
                ck = core_key;
                cb = core_block;
                @(posedge clk);
                #1 core_busy = 1'b1;
                repeat (stub_delay) @(posedge clk);
                #1 core_valid = 1'b1;
                core_out = core_model(ck, cb);
                @(posedge clk);
                #1 core_valid = 1'b0;
                core_out = '0;
                repeat (stub_tail) @(posedge clk);
                #1 core_busy = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 20000 cycles");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input logic [3:0] m);
        @(posedge clk);
        #1 req_valid = m;
    endtask

    task automatic wait_grant(output int tg, output logic [3:0] g);
        tg = -1;
        g  = '0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (resp_valid || (core_busy && ((|req_ready) || core_start))) gap_bad++;
            if (|req_ready) begin
                tg = cyc + 1;
                g  = req_ready;
                break;
            end
        end
        chk("grant_seen", 128'(tg >= 0), 128'd1);
    endtask

    task automatic wait_resp(output int tr);
        tr = -1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (resp_valid) begin
                tr = cyc;
                break;
            end
        end
        chk("resp_seen", 128'(tr >= 0), 128'd1);
    endtask

    task automatic handshake(input logic [3:0] next_mask, output int h);
        resp_ready = 1'b1;
        @(posedge clk);
        #1 h = cyc;
        resp_ready = 1'b0;
        req_valid  = next_mask;
    endtask

    task automatic do_grant(input int id, input logic [3:0] after_mask, output int tg);
        logic [3:0] g;
        logic [3:0] e;
        e = 4'b0001 << id;
        wait_grant(tg, g);
        chk("grant_onehot", 128'(g), 128'(e));
        @(posedge clk);
        #1 req_valid = after_mask;
        @(negedge clk);
        chk("issue_core_start", 128'(core_start), 128'd1);
        chk("issue_core_key", core_key, tb_key[id]);
        chk("issue_core_block", core_block, tb_blk[id]);
    endtask

    task automatic do_resp(input int id, input logic [3:0] next_mask, input int tg, output int h);
        int tr;
        wait_resp(tr);
        chk("resp_id", 128'(resp_id), 128'(id));
        chk("resp_data", resp_data, core_model(tb_key[id], tb_blk[id]));
        chk("resp_err", 128'(resp_err), 128'd0);
        chk("latency", 128'(tr - tg), 128'd44);
        handshake(next_mask, h);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_req_ready", 128'(req_ready), 128'd0);
        chk("rst_resp_valid", 128'(resp_valid), 128'd0);
        chk("rst_resp_id", 128'(resp_id), 128'd0);
        chk("rst_resp_data", resp_data, 128'd0);
        chk("rst_resp_err", 128'(resp_err), 128'd0);
        chk("rst_err_timeout", 128'(err_timeout), 128'd0);
        chk("rst_core_start", 128'(core_start), 128'd0);
        chk("rst_core_key", core_key, 128'd0);
        chk("rst_core_block", core_block, 128'd0);
    endtask

    initial begin : main
        int tg;
        int tg2;
        int tr;
        int h;
        int extra;

        tb_key[0] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        tb_blk[0] = 128'h6bc1bee22e409f96e93d7e117393172a;
        tb_key[1] = 128'h603deb1015ca71be2b73aef0857d7781;
        tb_blk[1] = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
        tb_key[2] = FipsKey;
        tb_blk[2] = FipsPt;
        tb_key[3] = 128'h8e73b0f7da0e6452c810f32b809079e5;
        tb_blk[3] = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
        req_key    = {tb_key[3], tb_key[2], tb_key[1], tb_key[0]};
        req_block  = {tb_blk[3], tb_blk[2], tb_blk[1], tb_blk[0]};
        rst        = 1'b1;
        req_valid  = 4'hF;
        resp_ready = 1'b0;

        // Reset values, with requests pending to show no grant leaks through reset.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs();
        req_valid = '0;
        rst       = 1'b0;

        // Fairness: all four valid, then only 1 and 3 from rr_ptr=0.
        drive_req(4'hF);
        for (int k = 0; k < 8; k++) begin
            do_grant(k % 4, 4'hF, tg);
            do_resp(k % 4, (k == 7) ? 4'b1010 : 4'hF, tg, h);
        end
        do_grant(1, 4'b1010, tg);
        do_resp(1, 4'b1010, tg, h);
        do_grant(3, 4'b1010, tg);
        do_resp(3, 4'b1010, tg, h);
        do_grant(1, 4'b0000, tg);
        do_resp(1, 4'b0000, tg, h);

        // Single request on requester 2 with the FIPS-197 vector.
        drive_req(4'b0100);
        do_grant(2, 4'b0000, tg);
        do_resp(2, 4'b0000, tg, h);

        // Response backpressure with other requests pending (rr_ptr=3).
        drive_req(4'hF);
        do_grant(3, 4'hF, tg);
        wait_resp(tr);
        for (int i = 0; i < 10; i++) begin
            chk("bp_resp_valid", 128'(resp_valid), 128'd1);
            chk("bp_resp_id", 128'(resp_id), 128'd3);
            chk("bp_resp_data", resp_data, core_model(tb_key[3], tb_blk[3]));
            chk("bp_no_grant", 128'(req_ready), 128'd0);
            @(negedge clk);
        end
        handshake(4'hF, h);
        do_grant(0, 4'b0000, tg);
        chk("bp_grant_next_cycle", 128'(tg), 128'(h + 1));
        do_resp(0, 4'b0000, tg, h);

        // Timeout: core answers after the watchdog has fired.
        stub_delay = 70;
        drive_req(4'b0001);
        do_grant(0, 4'b0000, tg);
        while (cyc != tg + 64) @(negedge clk);
        chk("to_not_early", 128'(resp_valid), 128'd0);
        @(negedge clk);
        chk("to_resp_valid", 128'(resp_valid), 128'd1);
        chk("to_resp_err", 128'(resp_err), 128'd1);
        chk("to_resp_data", resp_data, 128'd0);
        chk("to_resp_id", 128'(resp_id), 128'd0);
        chk("to_err_timeout", 128'(err_timeout), 128'd1);
        handshake(4'b0000, h);
        extra = 0;
        repeat (30) begin
            @(negedge clk);
            if (resp_valid) extra++;
        end
        chk("to_late_valid_ignored", 128'(extra), 128'd0);
        chk("to_err_sticky", 128'(err_timeout), 128'd1);
        stub_delay = 42;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (!core_busy) break;
        end

        // Reset 20 cycles into WAIT; the still-busy core must hold off the next grant.
        drive_req(4'b0010);
        do_grant(1, 4'b0010, tg);
        while (cyc != tg + 20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_outputs();
        rst = 1'b0;
        gap_bad = 0;
        do_grant(1, 4'b0000, tg2);
        chk("rst_regrant_time", 128'(tg2 - tg), 128'd46);
        chk("rst_no_resp_or_busy_grant", 128'(gap_bad), 128'd0);
        do_resp(1, 4'b0000, tg2, h);

        // Busy gating: core stays busy 5 cycles past valid.
        stub_tail = 5;
        drive_req(4'hF);
        do_grant(2, 4'hF, tg);
        do_resp(2, 4'hF, tg, h);
        gap_bad = 0;
        do_grant(3, 4'b0000, tg2);
        chk("busy_grant_time", 128'(tg2 - tg), 128'd50);
        chk("busy_no_start", 128'(gap_bad), 128'd0);
        do_resp(3, 4'b0000, tg2, h);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
